delay_sequencer: RTL
====================

DELAY_SEQUENCER -- requirements
Module: delay_sequencer

Interface
REQ-001 Parameter: TIMEOUT, default 200000, maximum clk cycles allowed per wait before fault (nominal wait is 100000 clk cycles: 50000 ticks at clk/2).
REQ-002 Parameter: RELEASE_MIN, default 4, minimum clk cycles delay_run is held low between waits.
REQ-003 Port: clk, input, 1, single clock; all state on posedge clk.
REQ-004 Port: rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port: start, input, 1, synchronous request to run the sequence; honoured only in IDLE.
REQ-006 Port: delay_done, input, 1, completion flag from the down-counter timer; asynchronous to clk.
REQ-007 Port: delay_run, output, 1, enables the down-counter timer; low forces the timer to reload.
REQ-008 Port: step_strobe, output, 1, one-cycle pulse marking a valid step_data.
REQ-009 Port: step_data, output, 8, command byte of the current step.
REQ-010 Port: step_index, output, 2, index of the current step, 0..3.
REQ-011 Port: busy, output, 1, high whenever the FSM is not in IDLE.
REQ-012 Port: seq_done, output, 1, one-cycle pulse when all four steps complete.
REQ-013 Port: fault, output, 1, sticky timeout flag, cleared only by reset or the next accepted start.

Function
REQ-014 Fixed step table: index 0 = 0x38, 1 = 0x0C, 2 = 0x06, 3 = 0x01.
REQ-015 delay_done passes through a 2-flop synchronizer; the FSM uses only the synchronized copy (done_s).
REQ-016 States: IDLE, ISSUE, ARM, WAIT, RELEASE, FINISH, FAULT.
REQ-017 IDLE: on start=1, go to ISSUE with step_index=0, clear fault, and clear the timeout counter.
REQ-018 ISSUE: step_strobe=1 for exactly this cycle, step_data=table[step_index]; next state ARM.
REQ-019 ARM: set delay_run=1 and clear the timeout counter; next state WAIT.
REQ-020 WAIT: delay_run=1; the timeout counter increments each cycle and saturates.
REQ-021 WAIT exit on done_s=1: go to RELEASE.
REQ-022 WAIT exit when the counter reaches TIMEOUT: go to FAULT.
REQ-023 WAIT with both events in the same cycle: done_s wins.
REQ-024 RELEASE: delay_run=0; stay at least RELEASE_MIN cycles and until done_s=0.
REQ-025 RELEASE exit: if step_index=3, go to FINISH; otherwise increment step_index and go to ISSUE.
REQ-026 FINISH: seq_done=1 for one cycle; next state IDLE; step_index holds 3.
REQ-027 FAULT: delay_run=0, fault=1; next state IDLE; no seq_done.
REQ-028 start while busy is ignored; there is no queueing.
REQ-029 delay_run is registered (glitch-free) and high only in ARM and WAIT.
REQ-030 step_data holds its value between strobes.
REQ-031 A step's delay is timed after its strobe; the next strobe occurs only after done_s plus release.

Reset
REQ-032 rst_n=0 asynchronously forces IDLE and clears the synchronizer flops.
REQ-033 Reset values: delay_run=0, step_strobe=0, step_data=0x00, step_index=0, busy=0, seq_done=0, fault=0.
REQ-034 Reset mid-WAIT drops delay_run immediately (the timer reloads); no seq_done is produced.
REQ-035 After reset release, the first start is accepted on the first posedge clk.

Verification
REQ-036 Nominal run: start pulse, timer model asserts done 100000 clk after run rises -> four strobes with data 0x38, 0x0C, 0x06, 0x01 in order, then one seq_done, busy falls, fault=0.
REQ-037 Timeout: timer model never asserts done -> fault=1 exactly TIMEOUT+1 cycles after ARM, delay_run=0, step_index=0, no seq_done.
REQ-038 Sticky done: timer holds done high 10 cycles after run falls -> RELEASE lasts until done_s=0 and is never shorter than RELEASE_MIN; no spurious extra step.
REQ-039 Start during busy: pulse start at step 2 -> sequence unaffected, exactly four strobes total.
REQ-040 Reset mid-sequence: assert rst_n=0 during step 1 WAIT -> all outputs at reset values immediately; new start reruns from 0x38.
REQ-041 Race: done_s and the timeout limit coincide -> step advances and fault remains 0.

Source files
------------

// File: rtl/delay_sequencer.sv
// delay_sequencer
//   Issues a fixed four-step command table. After each step strobe it enables
//   an external down-counter timer (delay_run) and waits for its completion
//   flag. Then it holds the timer in reload for a minimum release window
//   before it moves to the next step. If a wait runs past TIMEOUT cycles the
//   sequence is aborted with a sticky fault.
//
// Ports
//   clk          single clock, all state on posedge
//   rst_n        asynchronous active-low reset
//   start        run request, honoured only while idle
//   delay_done   timer completion flag (asynchronous, synchronized here)
//   delay_run    timer enable; low forces the timer to reload (registered)
//   step_strobe  one-cycle pulse qualifying step_data
//   step_data    command byte of the current step, held between strobes
//   step_index   current step 0..3
//   busy         sequencer not idle
//   seq_done     one-cycle pulse after the last step's release
//   fault        sticky timeout flag, cleared by reset or an accepted start
module delay_sequencer #(
  parameter int TIMEOUT     = 200000,
  parameter int RELEASE_MIN = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       delay_done,
  output logic       delay_run,
  output logic       step_strobe,
  output logic [7:0] step_data,
  output logic [1:0] step_index,
  output logic       busy,
  output logic       seq_done,
  output logic       fault
);

  // One counter serves both the wait timeout and the release window. The two
  // phases never overlap.
  localparam int CNT_MAX = (TIMEOUT > RELEASE_MIN) ? TIMEOUT : RELEASE_MIN;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_SAT  = CW'(CNT_MAX);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] REL_LAST = CW'(RELEASE_MIN - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, ARM, WAIT, RELEASE, FINISH, FAULT} state_t;

  state_t        state, nextState;
  logic          doneMeta, doneS;
  logic [CW-1:0] cnt;
  logic [1:0]    idxNext;
  logic          cntClr, cntInc, faultSet, faultClr;

  function automatic logic [7:0] stepCmd(input logic [1:0] idx);
    case (idx)
      2'd0:    stepCmd = 8'h38;
      2'd1:    stepCmd = 8'h0C;
      2'd2:    stepCmd = 8'h06;
      default: stepCmd = 8'h01;
    endcase
  endfunction

  // Two-flop synchronizer for the timer completion flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      doneMeta <= 1'b0;
      doneS    <= 1'b0;
    end else begin
      doneMeta <= delay_done;
      doneS    <= doneMeta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    idxNext   = step_index;
    cntClr    = 1'b0;
    cntInc    = 1'b0;
    faultSet  = 1'b0;
    faultClr  = 1'b0;
    case (state)
      IDLE: if (start) begin
        nextState = ISSUE;
        idxNext   = 2'd0;
        cntClr    = 1'b1;
        faultClr  = 1'b1;
      end
      ISSUE: nextState = ARM;
      ARM: begin
        nextState = WAIT;
        cntClr    = 1'b1;
      end
      WAIT: begin
        cntInc = 1'b1;
        // Completion has priority over a coinciding timeout. The exit to
        // FAULT happens on the edge at which the count would reach TIMEOUT.
        if (doneS) begin
          nextState = RELEASE;
          cntClr    = 1'b1;
        end else if (cnt >= TO_LAST) begin
          nextState = FAULT;
          faultSet  = 1'b1;
        end
      end
      RELEASE: begin
        cntInc = 1'b1;
        // Hold for at least RELEASE_MIN cycles and until the timer flag has
        // cleared. A sticky flag would otherwise end the next wait at once.
        if ((cnt >= REL_LAST) && !doneS) begin
          if (step_index == 2'd3) begin
            nextState = FINISH;
          end else begin
            nextState = ISSUE;
            idxNext   = step_index + 2'd1;
          end
        end
      end
      FINISH:  nextState = IDLE;
      FAULT:   nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      step_index <= 2'd0;
      step_data  <= 8'h00;
      delay_run  <= 1'b0;
      fault      <= 1'b0;
    end else begin
      if (cntClr)                        cnt <= '0;
      else if (cntInc && cnt != CNT_SAT) cnt <= cnt + CW'(1);
      step_index <= idxNext;
      if (nextState == ISSUE) step_data <= stepCmd(idxNext);
      // Registered from the next state, so it is high exactly in ARM and WAIT.
      delay_run <= (nextState == ARM) || (nextState == WAIT);
      if (faultClr)      fault <= 1'b0;
      else if (faultSet) fault <= 1'b1;
    end
  end

  assign step_strobe = (state == ISSUE);
  assign busy        = (state != IDLE);
  assign seq_done    = (state == FINISH);

endmodule
